// File: rtl/bexkat_bus_pkg.sv
// Shared bexkat bus definitions: adapter FSM states,
// 32-bit lane masks and halfword address offsets.
package bexkat_bus_pkg;

  typedef enum logic [1:0] {
    IDLE,
    HI,
    LO,
    DONE
  } state_t;

  localparam logic [3:0] BE_HI = 4'b1100;
  localparam logic [3:0] BE_LO = 4'b0011;

  localparam logic [1:0] HALF_HI_OFS = 2'b00;
  localparam logic [1:0] HALF_LO_OFS = 2'b10;

  localparam logic [15:0] HALF_MISSING = 16'hFFFF;

endpackage

// File: rtl/bus_width_adapter16.sv
// 32-bit CPU bus to 16-bit big-endian halfword memory bus adapter.
// Ports: clk, reset_n (sync, active-low); cpu_* 32-bit slave side with
// waitrequest; mem_* 16-bit master side; bus_error pulses on timeout.
module bus_width_adapter16
  import bexkat_bus_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int TIMEOUT    = 255
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [31:0]           cpu_address,
  input  logic                  cpu_read,
  input  logic                  cpu_write,
  input  logic [31:0]           cpu_writedata,
  input  logic [3:0]            cpu_byteenable,
  output logic [31:0]           cpu_readdata,
  output logic                  cpu_waitrequest,
  output logic                  bus_error,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic [15:0]           mem_writedata,
  output logic [1:0]            mem_byteenable,
  input  logic [15:0]           mem_readdata,
  input  logic                  mem_waitrequest
);

  localparam int TW =
    (TIMEOUT > 255) ? $clog2(TIMEOUT) : 8;
  localparam logic [TW-1:0] TLIM =
    TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  state_t                 state;
  logic [ADDR_WIDTH-1:2]  word_q;
  logic [3:0]             be_q;
  logic [31:0]            wd_q;
  logic                   wr_q;
  logic [TW-1:0]          timer;

  logic                   start;
  logic                   req_hi;
  logic                   req_lo;
  logic                   lo_left;
  logic                   tmo_hit;
  logic                   unused_bits;

  // Byte offset is implied by the lane enables.
  assign unused_bits = ^cpu_address[1:0];

  assign start   = cpu_read | cpu_write;
  assign req_hi  = |(cpu_byteenable & BE_HI);
  assign req_lo  = |(cpu_byteenable & BE_LO);
  assign lo_left = |(be_q & BE_LO);

  // Timer holds the stall count of the edges already seen,
  // so the abort edge is the TIMEOUT-th stalled one.
  assign tmo_hit = (TIMEOUT != 0) && (timer == TLIM);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state           <= IDLE;
      cpu_waitrequest <= 1'b1;
      cpu_readdata    <= '0;
      bus_error       <= 1'b0;
      mem_address     <= '0;
      mem_read        <= 1'b0;
      mem_write       <= 1'b0;
      mem_writedata   <= '0;
      mem_byteenable  <= '0;
      word_q          <= '0;
      be_q            <= '0;
      wd_q            <= '0;
      wr_q            <= 1'b0;
      timer           <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          cpu_waitrequest <= 1'b1;
          bus_error       <= 1'b0;
          if (start) begin
            word_q       <= cpu_address[ADDR_WIDTH-1:2];
            be_q         <= cpu_byteenable;
            wd_q         <= cpu_writedata;
            wr_q         <= cpu_write;
            cpu_readdata <= '0;
            timer        <= '0;
            if (req_hi) begin
              state          <= HI;
              mem_read       <= ~cpu_write;
              mem_write      <= cpu_write;
              mem_address    <= {cpu_address[ADDR_WIDTH-1:2],
                                 HALF_HI_OFS};
              mem_byteenable <= cpu_byteenable[3:2];
              mem_writedata  <= cpu_writedata[31:16];
            end else if (req_lo) begin
              state          <= LO;
              mem_read       <= ~cpu_write;
              mem_write      <= cpu_write;
              mem_address    <= {cpu_address[ADDR_WIDTH-1:2],
                                 HALF_LO_OFS};
              mem_byteenable <= cpu_byteenable[1:0];
              mem_writedata  <= cpu_writedata[15:0];
            end else begin
              state           <= DONE;
              cpu_waitrequest <= 1'b0;
            end
          end
        end

        HI: begin
          if (!mem_waitrequest) begin
            timer <= '0;
            if (!wr_q) begin
              cpu_readdata[31:16] <= mem_readdata;
            end
            if (lo_left) begin
              // Strobe stays up; only the halfword moves.
              state          <= LO;
              mem_address    <= {word_q, HALF_LO_OFS};
              mem_byteenable <= be_q[1:0];
              mem_writedata  <= wd_q[15:0];
            end else begin
              state           <= DONE;
              mem_read        <= 1'b0;
              mem_write       <= 1'b0;
              cpu_waitrequest <= 1'b0;
            end
          end else if (tmo_hit) begin
            timer           <= '0;
            state           <= DONE;
            mem_read        <= 1'b0;
            mem_write       <= 1'b0;
            cpu_waitrequest <= 1'b0;
            bus_error       <= 1'b1;
            if (!wr_q) begin
              cpu_readdata[31:16] <= HALF_MISSING;
              if (lo_left) begin
                cpu_readdata[15:0] <= HALF_MISSING;
              end
            end
          end else begin
            timer <= timer + TW'(1);
          end
        end

        LO: begin
          if (!mem_waitrequest) begin
            timer           <= '0;
            state           <= DONE;
            mem_read        <= 1'b0;
            mem_write       <= 1'b0;
            cpu_waitrequest <= 1'b0;
            if (!wr_q) begin
              cpu_readdata[15:0] <= mem_readdata;
            end
          end else if (tmo_hit) begin
            timer           <= '0;
            state           <= DONE;
            mem_read        <= 1'b0;
            mem_write       <= 1'b0;
            cpu_waitrequest <= 1'b0;
            bus_error       <= 1'b1;
            if (!wr_q) begin
              cpu_readdata[15:0] <= HALF_MISSING;
            end
          end else begin
            timer <= timer + TW'(1);
          end
        end

        DONE: begin
          state           <= IDLE;
          cpu_waitrequest <= 1'b1;
          bus_error       <= 1'b0;
        end

        default: begin
          state           <= IDLE;
          cpu_waitrequest <= 1'b1;
          mem_read        <= 1'b0;
          mem_write       <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bus_width_adapter16.sv
// Directed bench for bus_width_adapter16 with a small halfword
// memory model (programmable stalls) and an access log.
module tb_bus_width_adapter16;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] cpu_address;
  logic        cpu_read;
  logic        cpu_write;
  logic [31:0] cpu_writedata;
  logic [3:0]  cpu_byteenable;
  logic [31:0] cpu_readdata;
  logic        cpu_waitrequest;
  logic        bus_error;
  logic [31:0] mem_address;
  logic        mem_read;
  logic        mem_write;
  logic [15:0] mem_writedata;
  logic [1:0]  mem_byteenable;
  logic [15:0] mem_readdata;
  logic        mem_waitrequest;

  always #5 clk = ~clk;

  bus_width_adapter16 #(
    .ADDR_WIDTH(32),
    .TIMEOUT   (4)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .cpu_address    (cpu_address),
    .cpu_read       (cpu_read),
    .cpu_write      (cpu_write),
    .cpu_writedata  (cpu_writedata),
    .cpu_byteenable (cpu_byteenable),
    .cpu_readdata   (cpu_readdata),
    .cpu_waitrequest(cpu_waitrequest),
    .bus_error      (bus_error),
    .mem_address    (mem_address),
    .mem_read       (mem_read),
    .mem_write      (mem_write),
    .mem_writedata  (mem_writedata),
    .mem_byteenable (mem_byteenable),
    .mem_readdata   (mem_readdata),
    .mem_waitrequest(mem_waitrequest)
  );

  int   stall_cfg = 0;
  logic stuck = 1'b0;
  int   age = 0;
  logic strobe;

  assign strobe = mem_read | mem_write;
  assign mem_waitrequest =
    stuck || (strobe && (age < stall_cfg));

  always_comb begin
    unique case (mem_address)
      32'h100: mem_readdata = 16'hDEAD;
      32'h102: mem_readdata = 16'hBEEF;
      32'h300: mem_readdata = 16'h1234;
      32'h302: mem_readdata = 16'h5678;
      default: mem_readdata = 16'hC0DE;
    endcase
  end

  logic [31:0] log_addr [64];
  logic [1:0]  log_be   [64];
  logic [15:0] log_data [64];
  logic        log_wr   [64];
  int          log_n  = 0;
  int          strb_n = 0;

  always @(posedge clk) begin
    if (strobe) strb_n++;
    if (strobe && !mem_waitrequest) begin
      if (log_n < 64) begin
        log_addr[log_n] = mem_address;
        log_be[log_n]   = mem_byteenable;
        log_data[log_n] = mem_writedata;
        log_wr[log_n]   = mem_write;
      end
      log_n++;
      age <= 0;
    end else if (strobe) begin
      age <= age + 1;
    end else begin
      age <= 0;
    end
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h",
                  tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic xfer(input logic rd, input logic wr,
                      input logic [31:0] a,
                      input logic [3:0] be,
                      input logic [31:0] wd,
                      output int lat);
    cpu_read       = rd;
    cpu_write      = wr;
    cpu_address    = a;
    cpu_byteenable = be;
    cpu_writedata  = wd;
    lat = 0;
    while (cpu_waitrequest && lat < 40) begin
      tick();
      lat++;
    end
  endtask

  task automatic idle();
    cpu_read  = 1'b0;
    cpu_write = 1'b0;
    tick();
  endtask

  int lat;
  int lb;
  int sb;

  initial begin
    reset_n        = 1'b0;
    cpu_address    = '0;
    cpu_read       = 1'b0;
    cpu_write      = 1'b0;
    cpu_writedata  = '0;
    cpu_byteenable = '0;
    tick();
    tick();
    check("rst_waitreq", 32'(cpu_waitrequest), 1);
    check("rst_mem_rd", 32'(mem_read), 0);
    check("rst_mem_wr", 32'(mem_write), 0);
    check("rst_mem_addr", mem_address, 0);
    check("rst_mem_be", 32'(mem_byteenable), 0);
    check("rst_rdata", cpu_readdata, 0);
    check("rst_buserr", 32'(bus_error), 0);
    reset_n = 1'b1;
    tick();

    // 1: 32-bit read, zero waits
    lb = log_n;
    xfer(1'b1, 1'b0, 32'h100, 4'hF, 32'h0, lat);
    check("t1_latency", 32'(lat), 3);
    check("t1_rdata", cpu_readdata, 32'hDEADBEEF);
    check("t1_buserr", 32'(bus_error), 0);
    check("t1_nacc", 32'(log_n - lb), 2);
    check("t1_addr_hi", log_addr[lb], 32'h100);
    check("t1_addr_lo", log_addr[lb+1], 32'h102);
    idle();
    check("t1_waitreq_back", 32'(cpu_waitrequest), 1);
    check("t1_rdata_hold", cpu_readdata, 32'hDEADBEEF);

    // 2: byte write, two memory stalls
    lb = log_n;
    sb = strb_n;
    stall_cfg = 2;
    xfer(1'b0, 1'b1, 32'h203, 4'b0001, 32'hA5, lat);
    check("t2_latency", 32'(lat), 4);
    check("t2_strobe_cyc", 32'(strb_n - sb), 3);
    check("t2_nacc", 32'(log_n - lb), 1);
    check("t2_addr", log_addr[lb], 32'h202);
    check("t2_be", 32'(log_be[lb]), 32'b01);
    check("t2_data", 32'(log_data[lb]), 32'h00A5);
    check("t2_is_wr", 32'(log_wr[lb]), 1);
    idle();
    stall_cfg = 0;

    // 3: upper halfword read only
    lb = log_n;
    xfer(1'b1, 1'b0, 32'h300, 4'b1100, 32'h0, lat);
    check("t3_latency", 32'(lat), 2);
    check("t3_rdata", cpu_readdata, 32'h12340000);
    check("t3_nacc", 32'(log_n - lb), 1);
    check("t3_addr", log_addr[lb], 32'h300);
    check("t3_be", 32'(log_be[lb]), 32'b11);
    idle();

    // 4: timeout with memory stuck busy
    lb = log_n;
    sb = strb_n;
    stuck = 1'b1;
    xfer(1'b1, 1'b0, 32'h400, 4'hF, 32'h0, lat);
    check("t4_latency", 32'(lat), 5);
    check("t4_strobe_cyc", 32'(strb_n - sb), 4);
    check("t4_rdata", cpu_readdata, 32'hFFFFFFFF);
    check("t4_buserr", 32'(bus_error), 1);
    check("t4_strobe_off", 32'(mem_read), 0);
    check("t4_nacc", 32'(log_n - lb), 0);
    stuck = 1'b0;
    idle();
    check("t4_buserr_pulse", 32'(bus_error), 0);
    check("t4_no_lo", 32'(strb_n - sb), 4);

    // 5: reset during the LO phase
    cpu_read       = 1'b1;
    cpu_address    = 32'h100;
    cpu_byteenable = 4'hF;
    tick();
    tick();
    check("t5_in_lo", mem_address, 32'h102);
    reset_n  = 1'b0;
    cpu_read = 1'b0;
    tick();
    check("t5_rst_rd", 32'(mem_read), 0);
    check("t5_rst_wait", 32'(cpu_waitrequest), 1);
    reset_n = 1'b1;
    lb = log_n;
    xfer(1'b1, 1'b0, 32'h100, 4'hF, 32'h0, lat);
    check("t5_latency", 32'(lat), 3);
    check("t5_rdata", cpu_readdata, 32'hDEADBEEF);
    check("t5_nacc", 32'(log_n - lb), 2);
    idle();

    // 6: back-to-back writes around a be=0 request
    lb = log_n;
    xfer(1'b0, 1'b1, 32'h500, 4'hF, 32'h11112222, lat);
    check("t6a_latency", 32'(lat), 3);
    tick();
    xfer(1'b0, 1'b1, 32'h504, 4'h0, 32'h0, lat);
    check("t6b_latency", 32'(lat), 1);
    check("t6b_nacc", 32'(log_n - lb), 2);
    tick();
    xfer(1'b1, 1'b1, 32'h600, 4'hF, 32'h33334444, lat);
    check("t6c_latency", 32'(lat), 3);
    idle();
    check("t6_nacc", 32'(log_n - lb), 4);
    check("t6_a0", log_addr[lb], 32'h500);
    check("t6_d0", 32'(log_data[lb]), 32'h1111);
    check("t6_a1", log_addr[lb+1], 32'h502);
    check("t6_d1", 32'(log_data[lb+1]), 32'h2222);
    check("t6_a2", log_addr[lb+2], 32'h600);
    check("t6_d3", 32'(log_data[lb+3]), 32'h4444);
    check("t6_wr_wins", 32'(log_wr[lb+3]), 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
